aes_round_sequencer: RTL and testbench

//  Iterative AES encryption controller. It owns the 128-bit cipher state register, the round

---
 rtl/aes_round_sequencer.sv | 92 +++++++++
 tb/tb_aes_round_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_sequencer.sv
// Iterative AES encryption controller: holds the cipher state and round counter and
// steps one external round datapath per clock, with valid/ready on both sides.
module aes_round_sequencer #(
    parameter int NR  = 10,
    parameter int RKW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [127:0]   pt,
    output logic [RKW-1:0] rk_idx,
    input  logic [127:0]   rk,
    output logic [127:0]   dp_state,
    output logic           dp_last,
    input  logic [127:0]   dp_result,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [127:0]   ct
);

    generate
        if (NR < 2 || (2 ** RKW) <= NR) begin : g_bad_params
            $error("aes_round_sequencer: need NR >= 2 and 2**RKW > NR");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [RKW-1:0] LP_NR  = RKW'(NR);
    localparam logic [RKW-1:0] LP_ONE = RKW'(1);

    state_t         r_state;
    state_t         w_next;
    logic [RKW-1:0] r_rnd;
    logic [127:0]   r_data;
    logic           w_accept;
    logic           w_last_rnd;

    assign w_accept   = (r_state == S_IDLE) && in_valid;
    assign w_last_rnd = (r_state == S_RUN) && (r_rnd == LP_NR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)   w_next = S_RUN;
            S_RUN:   if (w_last_rnd) w_next = S_DONE;
            S_DONE:  if (out_ready)  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
        dp_last   = w_last_rnd;
        rk_idx    = (r_state == S_RUN) ? r_rnd : '0;
    end

    // The initial AddRoundKey is folded into the accept edge, so RUN only ever
    // loads the shared datapath's result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
            r_rnd  <= '0;
        end else if (w_accept) begin
            r_data <= pt ^ rk;
            r_rnd  <= LP_ONE;
        end else if (r_state == S_RUN) begin
            r_data <= dp_result;
            if (!w_last_rnd) begin
                r_rnd <= r_rnd + LP_ONE;
            end
        end
    end

    assign dp_state = r_data;
    assign ct       = r_data;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: supplies a reference AES round datapath and key
// schedule around two instances (NR=10 and NR=14) and checks published ciphertexts.
module tb_aes_round_sequencer;

    logic         clk;
    logic         rst;

    logic         in_valid, in_ready, dp_last, out_valid, out_ready;
    logic [127:0] pt, rk, dp_state, dp_result, ct;
    logic [3:0]   rk_idx;

    logic         in_valid14, in_ready14, dp_last14, out_valid14, out_ready14;
    logic [127:0] pt14, rk14, dp_state14, dp_result14, ct14;
    logic [3:0]   rk_idx14;

    logic [7:0]   sbox [0:255];
    logic [127:0] ks10 [0:15];
    logic [127:0] ks14 [0:15];

    int total;
    int bad;

    typedef struct {
        string        name;
        logic [127:0] pt;
        logic [127:0] key;
        logic [127:0] ct;
    } vec_t;

    vec_t vecs [0:2];

    aes_round_sequencer #(.NR(10), .RKW(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pt        (pt),
        .rk_idx    (rk_idx),
        .rk        (rk),
        .dp_state  (dp_state),
        .dp_last   (dp_last),
        .dp_result (dp_result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ct        (ct)
    );

    aes_round_sequencer #(.NR(14), .RKW(4)) u_dut14 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid14),
        .in_ready  (in_ready14),
        .pt        (pt14),
        .rk_idx    (rk_idx14),
        .rk        (rk14),
        .dp_state  (dp_state14),
        .dp_last   (dp_last14),
        .dp_result (dp_result14),
        .out_valid (out_valid14),
        .out_ready (out_ready14),
        .ct        (ct14)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte 0 of every 128-bit bus is its most-significant byte (FIPS-197 order).
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [7:0]   b [0:15];
        logic [7:0]   t [0:15];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) b[i] = sbox[s[127-8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[4*c+r] = b[4*((c+r)%4)+r];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = t[i] ^ k[127-8*i -: 8];
        return res;
    endfunction

    assign rk          = ks10[rk_idx];
    assign dp_result   = aes_round(dp_state, rk, dp_last);
    assign rk14        = ks14[rk_idx14];
    assign dp_result14 = aes_round(dp_state14, rk14, dp_last14);

    task automatic init_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic expand(input logic [255:0] key, input int nk, input int nr, input bit to14);
        logic [31:0] w [0:59];
        logic [31:0] tmp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp = subword({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h000000};
                rc  = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                tmp = subword(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        for (int r = 0; r <= nr; r++) begin
            if (to14) ks14[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else      ks10[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts in IDLE, accepts one block on the NR=10 instance and returns in its DONE cycle.
    task automatic block10(input string nm, input logic [127:0] p, input logic [127:0] key,
                           input logic [127:0] exp);
        logic [6:0] act_v, exp_v;
        expand({key, 128'h0}, 4, 10, 1'b0);
        pt       = p;
        in_valid = 1'b1;
        chk({nm, "/idle_ready"}, 128'({in_ready, rk_idx}), 128'({1'b1, 4'd0}));
        tick();
        pt = ~p;
        chk({nm, "/ark0"}, dp_state, p ^ key);
        for (int r = 1; r <= 10; r++) begin
            act_v = {rk_idx, dp_last, in_ready, out_valid};
            exp_v = {4'(r), (r == 10), 1'b0, 1'b0};
            chk($sformatf("%s/round%0d", nm, r), 128'(act_v), 128'(exp_v));
            tick();
        end
        chk({nm, "/done_flags"}, 128'({out_valid, in_ready, dp_last}), 128'({1'b1, 1'b0, 1'b0}));
        chk({nm, "/ct"}, ct, exp);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout want $finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [6:0] act_v, exp_v;
        int         ov_hits;
        total = 0;
        bad   = 0;

        vecs[0] = '{"fips_c1", 128'h00112233445566778899aabbccddeeff,
                    128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[1] = '{"zero", 128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
        vecs[2] = '{"fips_b", 128'h3243f6a8885a308d313198a2e0370734,
                    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32};

        rst         = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        pt          = '0;
        in_valid14  = 1'b0;
        out_ready14 = 1'b1;
        pt14        = '0;
        for (int i = 0; i < 16; i++) begin
            ks10[i] = '0;
            ks14[i] = '0;
        end
        init_sbox();
        #1;
        chk("reset/flags", 128'({in_ready, out_valid, dp_last, rk_idx}), 128'({3'b100, 4'd0}));
        chk("reset/ct", ct, 128'h0);
        chk("reset/dp_state", dp_state, 128'h0);
        chk("reset14/flags", 128'({in_ready14, out_valid14, dp_last14, rk_idx14}),
            128'({3'b100, 4'd0}));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // Table: in_valid and out_ready stay high through RUN; both must be ignored there.
        for (int v = 0; v < 3; v++) begin
            out_ready = 1'b1;
            block10(vecs[v].name, vecs[v].pt, vecs[v].key, vecs[v].ct);
            in_valid = 1'b0;
            tick();
            chk({vecs[v].name, "/back_idle"}, 128'({in_ready, out_valid}), 128'({1'b1, 1'b0}));
        end

        // Backpressure: result held for 20 cycles while a new block is offered.
        out_ready = 1'b0;
        block10("bp", vecs[0].pt, vecs[0].key, vecs[0].ct);
        for (int i = 0; i < 20; i++) begin
            tick();
            act_v = {4'd0, out_valid, in_ready, dp_last};
            chk($sformatf("bp/hold%0d_flags", i), 128'(act_v), 128'({4'd0, 3'b100}));
            chk($sformatf("bp/hold%0d_ct", i), ct, vecs[0].ct);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp/release", 128'({in_ready, out_valid}), 128'({1'b1, 1'b0}));
        tick();
        chk("bp/stay_idle", 128'({in_ready, out_valid}), 128'({1'b1, 1'b0}));

        // Back-to-back: next accept lands exactly NR+2 cycles after the previous one.
        out_ready = 1'b1;
        block10("b2b_a", vecs[0].pt, vecs[0].key, vecs[0].ct);
        tick();
        block10("b2b_b", 128'h0, 128'h0, vecs[1].ct);
        in_valid = 1'b0;
        tick();
        chk("b2b/idle", 128'({in_ready, out_valid}), 128'({1'b1, 1'b0}));

        // Asynchronous reset while rnd == 5.
        expand({vecs[0].key, 128'h0}, 4, 10, 1'b0);
        pt       = vecs[0].pt;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        chk("arst/pre_rnd", 128'(rk_idx), 128'd5);
        #2;
        rst = 1'b1;
        #1;
        chk("arst/flags", 128'({in_ready, out_valid, dp_last, rk_idx}), 128'({3'b100, 4'd0}));
        chk("arst/ct", ct, 128'h0);
        chk("arst/dp_state", dp_state, 128'h0);
        tick();
        tick();
        rst     = 1'b0;
        ov_hits = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) ov_hits++;
        end
        chk("arst/no_out_valid", 128'(ov_hits), 128'd0);
        block10("arst_after", vecs[2].pt, vecs[2].key, vecs[2].ct);
        in_valid = 1'b0;
        tick();

        // NR=14 instance with the AES-256 key schedule.
        expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14, 1'b1);
        pt14       = 128'h00112233445566778899aabbccddeeff;
        in_valid14 = 1'b1;
        chk("aes256/idle_ready", 128'(in_ready14), 128'd1);
        tick();
        in_valid14 = 1'b0;
        for (int r = 1; r <= 14; r++) begin
            act_v = {rk_idx14, dp_last14, in_ready14, out_valid14};
            exp_v = {4'(r), (r == 14), 1'b0, 1'b0};
            chk($sformatf("aes256/round%0d", r), 128'(act_v), 128'(exp_v));
            tick();
        end
        chk("aes256/out_valid", 128'(out_valid14), 128'd1);
        chk("aes256/ct", ct14, 128'h8ea2b7ca516745bfeafc49904b496089);
        tick();
        chk("aes256/idle", 128'({in_ready14, out_valid14}), 128'({1'b1, 1'b0}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
